// File: rtl/elevator_motion_pkg.sv
// Shared definitions for the elevator goal-floor selector and the car-motion controller.
// Holds the floor label encodings, the motion state enum, default timing constants and
// small floor decode helpers. Both blocks must use these labels so their encodings agree.
package elevator_pkg;

    typedef logic [1:0] floor_t;

    localparam floor_t labelF1 = 2'b00;
    localparam floor_t labelF2 = 2'b01;
    localparam floor_t labelF3 = 2'b10;
    // 2'b11 is never a legal floor; the selector may present it as "no goal".
    localparam floor_t FloorInvalid = 2'b11;

    localparam int unsigned TravelCyclesDefault = 8;
    localparam int unsigned DoorCyclesDefault   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StMove,
        StDoor
    } motion_state_e;

    // One-hot {f3, f2, f1} for a floor label; zero for the invalid code.
    function automatic logic [2:0] floor_onehot(input floor_t f);
        logic [2:0] oh;
        oh = 3'b000;
        case (f)
            labelF1: oh = 3'b001;
            labelF2: oh = 3'b010;
            labelF3: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Pending-request LED for a floor label, leds = {led3, led2, led1}.
    function automatic logic led_of(input floor_t f, input logic [2:0] leds);
        return |(floor_onehot(f) & leds);
    endfunction

endpackage

// File: rtl/elevator_motion_if.sv
// Bundle between the goal-floor selector and the car-motion controller.
//   gf            goal floor from the selector (2'b11 = no valid goal)
//   led1..led3    pending-request LEDs from the request latch
//   floor         current car floor, fed back to the selector
//   move_handler  car is moving; the selector freezes gf while high
//   dir_up        travel direction, meaningful only while move_handler is high
//   door_open     door is open
//   clr1..clr3    one-cycle request-clear pulses to the latch
// master = selector/latch side, slave = motion controller side.
interface elevator_motion_if;
    import elevator_pkg::*;

    floor_t gf;
    logic   led1;
    logic   led2;
    logic   led3;
    floor_t floor;
    logic   move_handler;
    logic   dir_up;
    logic   door_open;
    logic   clr1;
    logic   clr2;
    logic   clr3;

    modport master (
        output gf, led1, led2, led3,
        input  floor, move_handler, dir_up, door_open, clr1, clr2, clr3
    );

    modport slave (
        input  gf, led1, led2, led3,
        output floor, move_handler, dir_up, door_open, clr1, clr2, clr3
    );

endinterface

// File: rtl/elevator_motion_cycle_timer.sv
// Loadable up-counter with a terminal-count flag, shared by the travel and door phases.
//   clk, rst_n  clock and synchronous active-low reset
//   clear_i     force the count to zero on the next edge (wins over inc_i)
//   inc_i       advance the count by one
//   last_i      terminal value to compare against
//   done_o      count currently equals last_i
module cycle_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [Width-1:0] last_i,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == last_i);

endmodule

// File: rtl/elevator_motion.sv
// Car-motion controller downstream of the goal-floor selector.
// Steps the car one floor per TRAVEL_CYCLES toward a latched target, opens the door for
// DOOR_CYCLES on arrival (or on a request at the current floor) and pulses the matching
// request clear in the first door cycle. All outputs are registered.
//   clk, rst_n  clock and synchronous active-low reset
//   bus         slave side of elevator_motion_if (gf/leds in, floor/status/clears out)
module elevator_motion
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = TravelCyclesDefault,
    parameter int unsigned DOOR_CYCLES   = DoorCyclesDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    elevator_motion_if.slave  bus
);

    localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                      : DOOR_CYCLES;
    localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [TimerW-1:0] TravelLast = TimerW'(TRAVEL_CYCLES - 1);
    localparam logic [TimerW-1:0] DoorLast   = TimerW'(DOOR_CYCLES - 1);

    motion_state_e state_q, state_d;
    floor_t        floor_q, floor_d;
    floor_t        tgt_q, tgt_d;
    logic          move_q, move_d;
    logic          dir_up_q, dir_up_d;
    logic          door_q, door_d;
    logic [2:0]    clr_q, clr_d;

    logic              timer_clear;
    logic              timer_inc;
    logic              timer_done;
    logic [TimerW-1:0] timer_last;

    logic [2:0] leds;
    logic       req_here;
    logic       req_gf;
    logic       gf_ok;
    floor_t     floor_step;

    assign leds     = {bus.led3, bus.led2, bus.led1};
    assign req_here = led_of(floor_q, leds);
    assign req_gf   = led_of(bus.gf, leds);
    assign gf_ok    = (bus.gf != FloorInvalid) && (bus.gf != floor_q);
    // Direction is set toward a valid target, so the step never leaves F1..F3.
    assign floor_step = dir_up_q ? floor_q + 2'd1 : floor_q - 2'd1;
    assign timer_last = (state_q == StMove) ? TravelLast : DoorLast;

    cycle_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (timer_clear),
        .inc_i   (timer_inc),
        .last_i  (timer_last),
        .done_o  (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        tgt_d       = tgt_q;
        move_d      = move_q;
        dir_up_d    = dir_up_q;
        door_d      = door_q;
        clr_d       = 3'b000;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Timer is held at zero so every phase starts counting from 0.
                timer_clear = 1'b1;
                if (req_here) begin
                    state_d = StDoor;
                    door_d  = 1'b1;
                    clr_d   = floor_onehot(floor_q);
                end else if (gf_ok && req_gf) begin
                    state_d  = StMove;
                    tgt_d    = bus.gf;
                    dir_up_d = (bus.gf > floor_q);
                    move_d   = 1'b1;
                end
            end
            StMove: begin
                if (timer_done) begin
                    timer_clear = 1'b1;
                    floor_d     = floor_step;
                    if (floor_step == tgt_q) begin
                        state_d = StDoor;
                        move_d  = 1'b0;
                        door_d  = 1'b1;
                        clr_d   = floor_onehot(floor_step);
                    end
                end else begin
                    timer_inc = 1'b1;
                end
            end
            StDoor: begin
                if (timer_done) begin
                    timer_clear = 1'b1;
                    state_d     = StIdle;
                    door_d      = 1'b0;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: begin
                timer_clear = 1'b1;
                state_d     = StIdle;
                move_d      = 1'b0;
                door_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            floor_q  <= labelF1;
            tgt_q    <= labelF1;
            move_q   <= 1'b0;
            dir_up_q <= 1'b0;
            door_q   <= 1'b0;
            clr_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            tgt_q    <= tgt_d;
            move_q   <= move_d;
            dir_up_q <= dir_up_d;
            door_q   <= door_d;
            clr_q    <= clr_d;
        end
    end

    assign bus.floor        = floor_q;
    assign bus.move_handler = move_q;
    assign bus.dir_up       = dir_up_q;
    assign bus.door_open    = door_q;
    assign bus.clr1         = clr_q[0];
    assign bus.clr2         = clr_q[1];
    assign bus.clr3         = clr_q[2];

endmodule

// File: tb/tb_elevator_motion.sv
// Directed self-checking bench for elevator_motion with default timing (travel 8, door 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_elevator_motion;
    import elevator_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    elevator_motion_if bus ();

    elevator_motion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [2:0] clr_vec();
        return {bus.clr3, bus.clr2, bus.clr1};
    endfunction

    // Called on the first sample with the door open. Emulates the request latch by
    // dropping LEDs on a clear pulse, and returns one cycle after the door closes.
    task automatic watch_door(input string tag, input logic [2:0] exp_clr);
        int door_cnt;
        int clr_cnt;
        door_cnt = 0;
        clr_cnt  = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.door_open) door_cnt++;
            if (clr_vec() != 3'b000) begin
                clr_cnt++;
                chk({tag, "_clr"}, {5'd0, clr_vec()}, {5'd0, exp_clr});
                if (bus.clr1) bus.led1 = 1'b0;
                if (bus.clr2) bus.led2 = 1'b0;
                if (bus.clr3) bus.led3 = 1'b0;
            end
            chk({tag, "_excl"}, {7'd0, bus.move_handler & bus.door_open}, 8'd0);
            tick(1);
        end
        chk({tag, "_door_cycles"}, 8'(door_cnt), 8'd4);
        chk({tag, "_clr_pulses"}, 8'(clr_cnt), 8'd1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        bus.gf   = labelF3;
        bus.led1 = 1'b0;
        bus.led2 = 1'b0;
        bus.led3 = 1'b1;

        // Reset held with a pending request.
        tick(3);
        chk("rst_floor", {6'd0, bus.floor}, {6'd0, labelF1});
        chk("rst_mh", {7'd0, bus.move_handler}, 8'd0);
        chk("rst_door", {7'd0, bus.door_open}, 8'd0);
        chk("rst_clr", {5'd0, clr_vec()}, 8'd0);

        // Reset in the middle of a move.
        rst_n = 1'b1;
        tick(1);
        chk("mid_mh_up", {7'd0, bus.move_handler}, 8'd1);
        tick(4);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_floor", {6'd0, bus.floor}, {6'd0, labelF1});
        chk("mid_rst_mh", {7'd0, bus.move_handler}, 8'd0);
        chk("mid_rst_dir", {7'd0, bus.dir_up}, 8'd0);
        chk("mid_rst_door", {7'd0, bus.door_open}, 8'd0);
        rst_n = 1'b1;

        // Up two floors, F1 -> F3, passing F2.
        tick(1);
        chk("up_mh", {7'd0, bus.move_handler}, 8'd1);
        chk("up_dir", {7'd0, bus.dir_up}, 8'd1);
        tick(7);
        chk("up_f1_hold", {6'd0, bus.floor}, {6'd0, labelF1});
        tick(1);
        chk("up_f2", {6'd0, bus.floor}, {6'd0, labelF2});
        chk("up_f2_mh", {7'd0, bus.move_handler}, 8'd1);
        chk("up_f2_door", {7'd0, bus.door_open}, 8'd0);
        tick(7);
        chk("up_f2_hold", {6'd0, bus.floor}, {6'd0, labelF2});
        tick(1);
        chk("up_f3", {6'd0, bus.floor}, {6'd0, labelF3});
        chk("up_f3_mh", {7'd0, bus.move_handler}, 8'd0);
        chk("up_f3_door", {7'd0, bus.door_open}, 8'd1);
        watch_door("up", 3'b100);
        chk("up_idle_door", {7'd0, bus.door_open}, 8'd0);
        chk("up_idle_mh", {7'd0, bus.move_handler}, 8'd0);

        // F3 -> F2 to position the car.
        bus.gf   = labelF2;
        bus.led2 = 1'b1;
        tick(1);
        chk("f3f2_mh", {7'd0, bus.move_handler}, 8'd1);
        chk("f3f2_dir", {7'd0, bus.dir_up}, 8'd0);
        tick(8);
        chk("f3f2_floor", {6'd0, bus.floor}, {6'd0, labelF2});
        chk("f3f2_door", {7'd0, bus.door_open}, 8'd1);
        watch_door("f3f2", 3'b010);

        // Request at the current floor: no move, door reopens.
        bus.led2 = 1'b1;
        tick(1);
        chk("here_mh", {7'd0, bus.move_handler}, 8'd0);
        chk("here_door", {7'd0, bus.door_open}, 8'd1);
        watch_door("here", 3'b010);
        chk("here_floor", {6'd0, bus.floor}, {6'd0, labelF2});

        // Down one floor, F2 -> F1.
        bus.gf   = labelF1;
        bus.led1 = 1'b1;
        tick(1);
        chk("dn_mh", {7'd0, bus.move_handler}, 8'd1);
        chk("dn_dir", {7'd0, bus.dir_up}, 8'd0);
        tick(7);
        chk("dn_hold", {6'd0, bus.floor}, {6'd0, labelF2});
        tick(1);
        chk("dn_floor", {6'd0, bus.floor}, {6'd0, labelF1});
        chk("dn_door", {7'd0, bus.door_open}, 8'd1);
        watch_door("dn", 3'b001);
        chk("dn_idle_mh", {7'd0, bus.move_handler}, 8'd0);
        chk("dn_idle_door", {7'd0, bus.door_open}, 8'd0);

        // Target latch: goal change mid-move is ignored, F2 serviced afterwards.
        bus.gf   = labelF3;
        bus.led3 = 1'b1;
        tick(1);
        chk("lat_mh", {7'd0, bus.move_handler}, 8'd1);
        tick(3);
        bus.gf   = labelF2;
        bus.led2 = 1'b1;
        tick(5);
        chk("lat_pass_f2", {6'd0, bus.floor}, {6'd0, labelF2});
        chk("lat_pass_mh", {7'd0, bus.move_handler}, 8'd1);
        chk("lat_pass_door", {7'd0, bus.door_open}, 8'd0);
        tick(8);
        chk("lat_f3", {6'd0, bus.floor}, {6'd0, labelF3});
        chk("lat_f3_door", {7'd0, bus.door_open}, 8'd1);
        watch_door("lat", 3'b100);
        chk("svc_mh", {7'd0, bus.move_handler}, 8'd1);
        chk("svc_dir", {7'd0, bus.dir_up}, 8'd0);
        tick(8);
        chk("svc_floor", {6'd0, bus.floor}, {6'd0, labelF2});
        chk("svc_door", {7'd0, bus.door_open}, 8'd1);
        watch_door("svc", 3'b010);

        // Invalid goal with no requests: nothing changes.
        bus.gf = FloorInvalid;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("inv_floor", {6'd0, bus.floor}, {6'd0, labelF2});
            chk("inv_outs", {4'd0, bus.move_handler, bus.door_open, bus.clr1 | bus.clr2,
                             bus.clr3}, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_motion.md
Name: elevator_motion

Overview:
Car-motion controller directly downstream of the goal-floor selector. Consumes the selected goal floor `gf` and the pending-request LEDs. Produces the current `floor` and the `move_handler` busy flag, both fed back to the selector. Steps the car one floor per travel interval, opens the door on arrival, and pulses a per-floor clear to the request latch.

Parameters:
labelF1, 2'b00, encoding of floor 1 (shared with the selector)
labelF2, 2'b01, encoding of floor 2
labelF3, 2'b10, encoding of floor 3
TRAVEL_CYCLES, 8, clock cycles to travel one floor (must be >= 2)
DOOR_CYCLES, 4, clock cycles the door stays open (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
gf  in  2  goal floor from the selector
led1  in  1  pending request, floor 1
led2  in  1  pending request, floor 2
led3  in  1  pending request, floor 3
floor  out  2  current car floor (labelF1..labelF3)
move_handler  out  1  high while the car is moving; the selector freezes gf while high
dir_up  out  1  1 = moving up, 0 = moving down; valid only when move_handler=1
door_open  out  1  door open
clr1  out  1  one-cycle pulse that clears the floor-1 request
clr2  out  1  one-cycle pulse that clears the floor-2 request
clr3  out  1  one-cycle pulse that clears the floor-3 request

Behaviour:
- Clocking and reset:
  - One clock domain, `clk`.
  - Reset is synchronous and active-low (`rst_n`) and overrides everything, including mid-move and mid-door.
  - Reset values: floor=labelF1, move_handler=0, dir_up=0, door_open=0, clr1..3=0, state=IDLE, timer=0, tgt=labelF1.
- States: IDLE, MOVE, DOOR.
- Definition: req_here = LED of the current floor; req_gf = LED selected by gf.
- IDLE:
  - If req_here: next state DOOR.
  - Else if gf is valid, gf != floor and req_gf: latch tgt=gf, set dir_up=(gf>floor), move_handler=1, timer=0; next state MOVE. Latency from request to move_handler rising is 1 cycle.
  - Else stay in IDLE.
  - gf=2'b11 is invalid: ignored, stay in IDLE.
- MOVE:
  - timer increments every cycle.
  - When timer==TRAVEL_CYCLES-1: floor steps +1 or -1 per dir_up, and timer=0.
  - If the new floor==tgt, on the same edge: move_handler=0, next state DOOR.
  - F1->F3 therefore takes exactly 2*TRAVEL_CYCLES cycles and passes through F2 without stopping.
  - gf and LED changes are ignored in MOVE. tgt is latched; the selector also holds gf while move_handler=1.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, then door_open=0, next state IDLE.
  - On the first DOOR cycle only, the clr output matching floor pulses high for one cycle.
  - A new press of the current floor during DOOR does not extend the door. It is serviced from IDLE afterwards (door reopens).
- Timer:
  - Single shared counter, width $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)).
  - Reset to 0 on every state transition.
- Invariants:
  - floor never leaves {labelF1, labelF2, labelF3}; the car never steps below F1 or above F3.
  - move_handler and door_open are never both high.
  - At most one clr output is high in any cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `elevator_pkg`:
  - floor label constants labelF1/F2/F3;
  - the motion state enum (IDLE, MOVE, DOOR);
  - default timing constants.
  The selector and this block must use the same labels.
- Sub-module `cycle_timer` (loadable up-counter with terminal-count flag) is natural.
- The rest stays flat in elevator_motion.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with led3=1 -> floor=00, move_handler=0, door_open=0, all clr=0. Repeat with reset asserted mid-MOVE -> same values on the next edge.
- Up two floors: floor=00, led3=1, gf=10 -> move_handler=1 after 1 cycle, dir_up=1; floor=01 at +8 cycles, floor=10 at +16 cycles; move_handler falls on that edge; door_open high 4 cycles; clr3 pulses once in the first door cycle.
- Down one floor: car at F2, led1=1, gf=00 -> dir_up=0, floor=00 after 8 cycles, clr1 pulse, door 4 cycles, then back to IDLE.
- Request at current floor: car idle at F2, led2=1, gf=01 -> no move; door_open 1 cycle later for 4 cycles; clr2 one pulse.
- Target latch: during F1->F3 move, change gf to 01 and set led2=1 -> car does not stop at F2, arrives at F3; afterwards services F2 from IDLE with dir_up=0.
- Invalid/idle: gf=11 with no LEDs for 20 cycles -> state stays IDLE, all outputs unchanged, no clr pulse.
